axi_lite_master: RTL and testbench



---
 rtl/axi_lite_pkg.sv | 27 ++
 rtl/axi_lite_master_if.sv | 58 +++++
 rtl/axi_lite_master.sv | 219 +++++++++++++++++++++
 tb/tb_axi_lite_master.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_lite_pkg.sv
// -----------------------------------------------------------------------------
// axi_lite_pkg
// Types and constants shared by the AXI4-Lite master and slave blocks.
//   resp_t         : BRESP/RRESP encodings
//   master_state_t : transaction state of axi_lite_master
// -----------------------------------------------------------------------------
package axi_lite_pkg;

   localparam int unsigned AXI_RESP_W = 2;
   localparam int unsigned AXI_PROT_W = 3;

   typedef enum logic [1:0] {
      OKAY   = 2'b00,
      EXOKAY = 2'b01,
      SLVERR = 2'b10,
      DECERR = 2'b11
   } resp_t;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WR_REQ  = 3'd1,
      WR_RESP = 3'd2,
      RD_REQ  = 3'd3,
      RD_DATA = 3'd4
   } master_state_t;

endpackage

// File: rtl/axi_lite_master_if.sv
// -----------------------------------------------------------------------------
// axi_lite_master_if
// The five AXI4-Lite channels between one master and one slave.
//   AW : awaddr, awprot, awvalid  (M->S), awready (S->M)
//   W  : wdata, wstrb, wvalid     (M->S), wready  (S->M)
//   B  : bresp, bvalid            (S->M), bready  (M->S)
//   AR : araddr, arprot, arvalid  (M->S), arready (S->M)
//   R  : rdata, rresp, rvalid     (S->M), rready  (M->S)
// -----------------------------------------------------------------------------
interface axi_lite_master_if
   import axi_lite_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   localparam int STRB_W = DATA_W / 8;

   logic [ADDR_W-1:0]     awaddr;
   logic [AXI_PROT_W-1:0] awprot;
   logic                  awvalid;
   logic                  awready;

   logic [DATA_W-1:0]     wdata;
   logic [STRB_W-1:0]     wstrb;
   logic                  wvalid;
   logic                  wready;

   logic [AXI_RESP_W-1:0] bresp;
   logic                  bvalid;
   logic                  bready;

   logic [ADDR_W-1:0]     araddr;
   logic [AXI_PROT_W-1:0] arprot;
   logic                  arvalid;
   logic                  arready;

   logic [DATA_W-1:0]     rdata;
   logic [AXI_RESP_W-1:0] rresp;
   logic                  rvalid;
   logic                  rready;

   modport master (
      output awaddr, awprot, awvalid, input awready,
      output wdata, wstrb, wvalid, input wready,
      input bresp, bvalid, output bready,
      output araddr, arprot, arvalid, input arready,
      input rdata, rresp, rvalid, output rready
   );

   modport slave (
      input awaddr, awprot, awvalid, output awready,
      input wdata, wstrb, wvalid, output wready,
      output bresp, bvalid, input bready,
      input araddr, arprot, arvalid, output arready,
      output rdata, rresp, rvalid, input rready
   );

endinterface

// File: rtl/axi_lite_master.sv
// -----------------------------------------------------------------------------
// axi_lite_master
// Turns single-beat user commands into AXI4-Lite write or read transactions,
// one outstanding at a time, and returns the slave response.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   cmd_valid/cmd_ready : command handshake (ready only while idle)
//   cmd_write           : 1 = write, 0 = read
//   cmd_addr/wdata/wstrb: command payload, latched at acceptance
//   rsp_valid           : one-cycle completion pulse
//   rsp_rdata           : last read data, held until the next read completes
//   rsp_resp            : BRESP/RRESP of the completed transaction
//   busy                : a transaction is in progress
//   m_axi               : AXI4-Lite master channels
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module axi_lite_master
   import axi_lite_pkg::*;
#(
   parameter int                    P_M_AXI_ADDR_WIDTH = 32,
   parameter int                    P_M_AXI_DATA_WIDTH = 32,
   parameter logic [AXI_PROT_W-1:0] P_M_AXI_PROT       = 3'b000
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            cmd_valid,
   output logic                            cmd_ready,
   input  logic                            cmd_write,
   input  logic [P_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
   input  logic [P_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
   input  logic [P_M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
   output logic                            rsp_valid,
   output logic [P_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
   output logic [AXI_RESP_W-1:0]           rsp_resp,
   output logic                            busy,
   axi_lite_master_if.master               m_axi
);

   localparam int STRB_W = P_M_AXI_DATA_WIDTH / 8;

   master_state_t state_r;
   master_state_t state_s;

   logic aw_done_r, w_done_r;
   logic aw_done_s, w_done_s;

   logic awvalid_r, wvalid_r, bready_r, arvalid_r, rready_r;
   logic awvalid_s, wvalid_s, bready_s, arvalid_s, rready_s;
   logic cmd_ready_r, busy_r, rsp_valid_r;
   logic cmd_ready_s, busy_s, rsp_valid_s;

   logic [P_M_AXI_ADDR_WIDTH-1:0] awaddr_r;
   logic [P_M_AXI_ADDR_WIDTH-1:0] araddr_r;
   logic [P_M_AXI_DATA_WIDTH-1:0] wdata_r;
   logic [STRB_W-1:0]             wstrb_r;
   logic [P_M_AXI_DATA_WIDTH-1:0] rsp_rdata_r;
   logic [AXI_RESP_W-1:0]         rsp_resp_r;

   logic accept_s, aw_hs_s, w_hs_s, b_hs_s, ar_hs_s, r_hs_s;

   // Handshake decodes; each term pairs a registered output with a slave input.
   always_comb begin
      accept_s = cmd_valid & cmd_ready_r;
      aw_hs_s  = awvalid_r & m_axi.awready;
      w_hs_s   = wvalid_r  & m_axi.wready;
      b_hs_s   = bready_r  & m_axi.bvalid;
      ar_hs_s  = arvalid_r & m_axi.arready;
      r_hs_s   = rready_r  & m_axi.rvalid;
   end

   // Per-channel completion of the write request, including this cycle's handshake.
   always_comb begin
      if (state_r == WR_REQ) begin
         aw_done_s = aw_done_r | aw_hs_s;
         w_done_s  = w_done_r  | w_hs_s;
      end else begin
         aw_done_s = 1'b0;
         w_done_s  = 1'b0;
      end
   end

   // Next-state logic.
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (accept_s) begin
               if (cmd_write) state_s = WR_REQ;
               else           state_s = RD_REQ;
            end else begin
               state_s = IDLE;
            end
         end
         WR_REQ: begin
            // Both channels may finish on the same edge.
            if (aw_done_s && w_done_s) state_s = WR_RESP;
            else                       state_s = WR_REQ;
         end
         WR_RESP: begin
            if (b_hs_s) state_s = IDLE;
            else        state_s = WR_RESP;
         end
         RD_REQ: begin
            if (ar_hs_s) state_s = RD_DATA;
            else         state_s = RD_REQ;
         end
         RD_DATA: begin
            if (r_hs_s) state_s = IDLE;
            else        state_s = RD_DATA;
         end
         default: state_s = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_r <= IDLE;
      else     state_r <= state_s;
   end

   // Output decode: values the control flops take on the coming edge.
   always_comb begin
      awvalid_s   = 1'b0;
      wvalid_s    = 1'b0;
      arvalid_s   = 1'b0;
      // Request valids rise one cycle after the state is entered and fall on
      // the edge that completes their own handshake.
      if ((state_r == WR_REQ) && (state_s == WR_REQ)) begin
         awvalid_s = ~aw_done_s;
         wvalid_s  = ~w_done_s;
      end else begin
         awvalid_s = 1'b0;
         wvalid_s  = 1'b0;
      end
      if ((state_r == RD_REQ) && (state_s == RD_REQ)) arvalid_s = 1'b1;
      else                                            arvalid_s = 1'b0;
      bready_s    = (state_s == WR_RESP);
      rready_s    = (state_s == RD_DATA);
      cmd_ready_s = (state_s == IDLE);
      busy_s      = (state_s != IDLE);
      rsp_valid_s = b_hs_s | r_hs_s;
   end

   // Control output and channel-completion flag registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         awvalid_r   <= 1'b0;
         wvalid_r    <= 1'b0;
         bready_r    <= 1'b0;
         arvalid_r   <= 1'b0;
         rready_r    <= 1'b0;
         cmd_ready_r <= 1'b1;
         busy_r      <= 1'b0;
         rsp_valid_r <= 1'b0;
         aw_done_r   <= 1'b0;
         w_done_r    <= 1'b0;
      end else begin
         awvalid_r   <= awvalid_s;
         wvalid_r    <= wvalid_s;
         bready_r    <= bready_s;
         arvalid_r   <= arvalid_s;
         rready_r    <= rready_s;
         cmd_ready_r <= cmd_ready_s;
         busy_r      <= busy_s;
         rsp_valid_r <= rsp_valid_s;
         // Flags clear as soon as the write request phase ends.
         aw_done_r   <= (state_s == WR_REQ) ? aw_done_s : 1'b0;
         w_done_r    <= (state_s == WR_REQ) ? w_done_s  : 1'b0;
      end
   end

   // Request payload capture at acceptance and response capture at completion.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         awaddr_r    <= {P_M_AXI_ADDR_WIDTH{1'b0}};
         araddr_r    <= {P_M_AXI_ADDR_WIDTH{1'b0}};
         wdata_r     <= {P_M_AXI_DATA_WIDTH{1'b0}};
         wstrb_r     <= {STRB_W{1'b0}};
         rsp_rdata_r <= {P_M_AXI_DATA_WIDTH{1'b0}};
         rsp_resp_r  <= 2'b00;
      end else begin
         if (accept_s) begin
            if (cmd_write) begin
               awaddr_r <= cmd_addr;
               wdata_r  <= cmd_wdata;
               wstrb_r  <= cmd_wstrb;
            end else begin
               araddr_r <= cmd_addr;
            end
         end
         // Error codes are passed through untouched; there is no retry.
         if (b_hs_s) begin
            rsp_resp_r <= m_axi.bresp;
         end else if (r_hs_s) begin
            rsp_resp_r  <= m_axi.rresp;
            rsp_rdata_r <= m_axi.rdata;
         end
      end
   end

   assign cmd_ready = cmd_ready_r;
   assign busy      = busy_r;
   assign rsp_valid = rsp_valid_r;
   assign rsp_rdata = rsp_rdata_r;
   assign rsp_resp  = rsp_resp_r;

   assign m_axi.awaddr  = awaddr_r;
   assign m_axi.awprot  = P_M_AXI_PROT;
   assign m_axi.awvalid = awvalid_r;
   assign m_axi.wdata   = wdata_r;
   assign m_axi.wstrb   = wstrb_r;
   assign m_axi.wvalid  = wvalid_r;
   assign m_axi.bready  = bready_r;
   assign m_axi.araddr  = araddr_r;
   assign m_axi.arprot  = P_M_AXI_PROT;
   assign m_axi.arvalid = arvalid_r;
   assign m_axi.rready  = rready_r;

endmodule

// File: tb/tb_axi_lite_master.sv
// -----------------------------------------------------------------------------
// tb_axi_lite_master
// Directed bench for axi_lite_master with a configurable slave stub
// (per-channel ready delays, forced responses, read stall) and a monitor
// that logs handshake counts and edge indices.
// -----------------------------------------------------------------------------
module tb_axi_lite_master;

   localparam int AW = 32;
   localparam int DW = 32;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid, cmd_write;
   logic [31:0] cmd_addr, cmd_wdata;
   logic [3:0]  cmd_wstrb;
   logic        cmd_ready, rsp_valid, busy;
   logic [31:0] rsp_rdata;
   logic [1:0]  rsp_resp;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   axi_lite_master_if #(.ADDR_W(AW), .DATA_W(DW)) axi ();

   axi_lite_master #(
      .P_M_AXI_ADDR_WIDTH(AW),
      .P_M_AXI_DATA_WIDTH(DW),
      .P_M_AXI_PROT(3'b000)
   ) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
      .busy(busy), .m_axi(axi)
   );

   // ---------------- slave stub ----------------
   int          aw_delay = 0, w_delay = 0;
   logic [1:0]  cfg_bresp = 2'b00, cfg_rresp = 2'b00;
   logic        cfg_r_override = 1'b0, cfg_r_stall = 1'b0;
   logic [31:0] cfg_rdata = 32'h0;

   int          aw_wait, w_wait;
   logic        aw_got, w_got;
   logic [31:0] aw_lat, w_lat;
   logic [3:0]  ws_lat;
   logic        s_bvalid, s_rvalid;
   logic [1:0]  s_bresp, s_rresp;
   logic [31:0] s_rdata;
   logic [31:0] mem [0:15];
   logic        aw_hs_now, w_hs_now;
   logic [31:0] wr_addr, wr_data;
   logic [3:0]  wr_strb;

   assign axi.awready = (aw_wait >= aw_delay);
   assign axi.wready  = (w_wait >= w_delay);
   assign axi.arready = 1'b1;
   assign axi.bvalid  = s_bvalid;
   assign axi.bresp   = s_bresp;
   assign axi.rvalid  = s_rvalid;
   assign axi.rdata   = s_rdata;
   assign axi.rresp   = s_rresp;

   assign aw_hs_now = axi.awvalid & axi.awready;
   assign w_hs_now  = axi.wvalid & axi.wready;
   assign wr_addr   = aw_got ? aw_lat : axi.awaddr;
   assign wr_data   = w_got ? w_lat : axi.wdata;
   assign wr_strb   = w_got ? ws_lat : axi.wstrb;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         aw_wait  <= 0;
         w_wait   <= 0;
         aw_got   <= 1'b0;
         w_got    <= 1'b0;
         aw_lat   <= 32'h0;
         w_lat    <= 32'h0;
         ws_lat   <= 4'h0;
         s_bvalid <= 1'b0;
         s_bresp  <= 2'b00;
         s_rvalid <= 1'b0;
         s_rresp  <= 2'b00;
         s_rdata  <= 32'h0;
      end else begin
         if (aw_hs_now)        aw_wait <= 0;
         else if (axi.awvalid) aw_wait <= aw_wait + 1;
         if (w_hs_now)         w_wait <= 0;
         else if (axi.wvalid)  w_wait <= w_wait + 1;

         if (s_bvalid && axi.bready) s_bvalid <= 1'b0;
         if ((aw_got || aw_hs_now) && (w_got || w_hs_now)) begin
            for (int b = 0; b < 4; b++)
               if (wr_strb[b]) mem[wr_addr[3:0]][8*b +: 8] <= wr_data[8*b +: 8];
            s_bvalid <= 1'b1;
            s_bresp  <= cfg_bresp;
            aw_got   <= 1'b0;
            w_got    <= 1'b0;
         end else begin
            if (aw_hs_now) begin aw_got <= 1'b1; aw_lat <= axi.awaddr; end
            if (w_hs_now)  begin w_got <= 1'b1; w_lat <= axi.wdata; ws_lat <= axi.wstrb; end
         end

         if (s_rvalid && axi.rready) s_rvalid <= 1'b0;
         if (axi.arvalid && axi.arready && !cfg_r_stall) begin
            s_rvalid <= 1'b1;
            s_rdata  <= cfg_r_override ? cfg_rdata : mem[axi.araddr[3:0]];
            s_rresp  <= cfg_rresp;
         end
      end
   end

   // ---------------- monitor ----------------
   int cyc = 0;
   int acc_cnt = 0, acc_edge = 0;
   int aw_hs_cnt = 0, aw_hs_edge = 0, w_hs_cnt = 0, w_hs_edge = 0;
   int b_hs_cnt = 0, b_hs_edge = 0, ar_hs_cnt = 0, ar_hs_edge = 0;
   int rsp_cnt = 0, rsp_edge = 0;
   int awv_cyc = 0, wv_cyc = 0, rr_cyc = 0, br_cyc = 0;
   int aw_unstable = 0, w_unstable = 0;
   int bready_rise = 0;
   logic        rsp_cmd_ready = 1'b0;
   logic        prev_awvalid = 1'b0, prev_wvalid = 1'b0, prev_bready = 1'b0;
   logic [31:0] prev_awaddr = 32'h0, prev_wdata = 32'h0;
   logic [31:0] seen_awaddr = 32'h0, seen_wdata = 32'h0, seen_araddr = 32'h0;
   logic [3:0]  seen_wstrb = 4'h0;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (cmd_valid && cmd_ready) begin acc_cnt <= acc_cnt + 1; acc_edge <= cyc; end
      if (aw_hs_now) begin aw_hs_cnt <= aw_hs_cnt + 1; aw_hs_edge <= cyc; seen_awaddr <= axi.awaddr; end
      if (w_hs_now) begin
         w_hs_cnt <= w_hs_cnt + 1; w_hs_edge <= cyc;
         seen_wdata <= axi.wdata; seen_wstrb <= axi.wstrb;
      end
      if (axi.bvalid && axi.bready) begin b_hs_cnt <= b_hs_cnt + 1; b_hs_edge <= cyc; end
      if (axi.arvalid && axi.arready) begin ar_hs_cnt <= ar_hs_cnt + 1; ar_hs_edge <= cyc; seen_araddr <= axi.araddr; end
      if (rsp_valid) begin rsp_cnt <= rsp_cnt + 1; rsp_edge <= cyc; rsp_cmd_ready <= cmd_ready; end
      if (axi.awvalid) awv_cyc <= awv_cyc + 1;
      if (axi.wvalid)  wv_cyc <= wv_cyc + 1;
      if (axi.rready)  rr_cyc <= rr_cyc + 1;
      if (axi.bready)  br_cyc <= br_cyc + 1;
      if (axi.awvalid && prev_awvalid && (axi.awaddr != prev_awaddr)) aw_unstable <= aw_unstable + 1;
      if (axi.wvalid && prev_wvalid && (axi.wdata != prev_wdata))     w_unstable <= w_unstable + 1;
      if (axi.bready && !prev_bready) bready_rise <= cyc;
      prev_awvalid <= axi.awvalid;
      prev_wvalid  <= axi.wvalid;
      prev_bready  <= axi.bready;
      prev_awaddr  <= axi.awaddr;
      prev_wdata   <= axi.wdata;
   end

   // ---------------- helpers ----------------
   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      int snap;
      snap = acc_cnt;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
      for (int i = 0; i < 40 && acc_cnt == snap; i++) @(negedge clk);
      cmd_valid = 1'b0;
      check("accept", acc_cnt - snap, 1);
   endtask

   task automatic wait_rsp(input int snap);
      for (int i = 0; i < 60 && rsp_cnt == snap; i++) @(negedge clk);
      @(negedge clk);
      check("rsp_one_pulse", rsp_cnt - snap, 1);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int r0, aw0, w0, ar0, awv0, wv0, rr0, br0, awu0, wu0, a0, first_edge;
      rst = 1'b1;
      cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'h0; cmd_wdata = 32'h0; cmd_wstrb = 4'h0;
      repeat (3) @(negedge clk);

      // Reset values
      check("rst_valids", {axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready}, 5'b0);
      check("rst_rsp_busy", {rsp_valid, busy, rsp_resp}, 4'b0);
      check("rst_payload", {axi.awaddr, axi.wdata, axi.wstrb, axi.araddr, rsp_rdata}, 132'h0);
      check("rst_cmd_ready", cmd_ready, 1'b1);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Basic write, zero-wait slave
      r0 = rsp_cnt; aw0 = aw_hs_cnt; w0 = w_hs_cnt;
      send(1'b1, 32'h1, 32'h6, 4'hF);
      wait_rsp(r0);
      check("wr_aw_lat", aw_hs_edge - acc_edge, 2);
      check("wr_w_lat", w_hs_edge - acc_edge, 2);
      check("wr_b_lat", b_hs_edge - acc_edge, 3);
      check("wr_rsp_lat", rsp_edge - acc_edge, 4);
      check("wr_cmd_ready_back", rsp_cmd_ready, 1'b1);
      check("wr_hs_once", {aw_hs_cnt - aw0, w_hs_cnt - w0}, {32'd1, 32'd1});
      check("wr_awaddr", seen_awaddr, 32'h1);
      check("wr_wdata", seen_wdata, 32'h6);
      check("wr_wstrb", seen_wstrb, 4'hF);
      check("wr_resp", rsp_resp, 2'b00);

      // Read-back
      r0 = rsp_cnt; rr0 = rr_cyc; br0 = br_cyc;
      send(1'b0, 32'h1, 32'h0, 4'h0);
      wait_rsp(r0);
      check("rd_araddr", seen_araddr, 32'h1);
      check("rd_ar_lat", ar_hs_edge - acc_edge, 2);
      check("rd_rsp_lat", rsp_edge - acc_edge, 4);
      check("rd_rdata", rsp_rdata, 32'h6);
      check("rd_resp", rsp_resp, 2'b00);
      check("rd_rready_cycles", rr_cyc - rr0, 1);
      check("rd_no_bready", br_cyc - br0, 0);

      // AWREADY delayed 3 cycles, WREADY immediate
      aw_delay = 3; w_delay = 0;
      r0 = rsp_cnt; awv0 = awv_cyc; wv0 = wv_cyc; awu0 = aw_unstable;
      send(1'b1, 32'h4, 32'hA5, 4'hF);
      wait_rsp(r0);
      check("skew_wvalid_cycles", wv_cyc - wv0, 1);
      check("skew_awvalid_cycles", awv_cyc - awv0, 4);
      check("skew_awaddr_stable", aw_unstable - awu0, 0);
      check("skew_awaddr", seen_awaddr, 32'h4);
      check("skew_bready_after_aw", bready_rise - aw_hs_edge, 1);
      check("skew_rsp_lat", rsp_edge - acc_edge, 7);

      // WREADY delayed 3 cycles, AWREADY immediate
      aw_delay = 0; w_delay = 3;
      r0 = rsp_cnt; awv0 = awv_cyc; wv0 = wv_cyc; wu0 = w_unstable;
      send(1'b1, 32'h6, 32'h5A, 4'h3);
      wait_rsp(r0);
      check("swap_awvalid_cycles", awv_cyc - awv0, 1);
      check("swap_wvalid_cycles", wv_cyc - wv0, 4);
      check("swap_wdata_stable", w_unstable - wu0, 0);
      check("swap_bready_after_w", bready_rise - w_hs_edge, 1);
      check("swap_wstrb", seen_wstrb, 4'h3);

      // Both channels handshake on the same edge after a 2-cycle wait
      aw_delay = 2; w_delay = 2;
      r0 = rsp_cnt; awv0 = awv_cyc; wv0 = wv_cyc;
      send(1'b1, 32'h7, 32'h77, 4'hF);
      wait_rsp(r0);
      check("same_hs_edge", aw_hs_edge - w_hs_edge, 0);
      check("same_awvalid_cycles", awv_cyc - awv0, 3);
      check("same_bready_rise", bready_rise - aw_hs_edge, 1);
      check("same_rsp_lat", rsp_edge - acc_edge, 6);
      aw_delay = 0; w_delay = 0;

      // Error passthrough, no retry
      aw0 = aw_hs_cnt; ar0 = ar_hs_cnt;
      cfg_bresp = 2'b10;
      r0 = rsp_cnt;
      send(1'b1, 32'h5, 32'h99, 4'hF);
      wait_rsp(r0);
      check("err_bresp", rsp_resp, 2'b10);
      cfg_bresp = 2'b00;
      cfg_rresp = 2'b11; cfg_r_override = 1'b1; cfg_rdata = 32'hDEADBEEF;
      r0 = rsp_cnt;
      send(1'b0, 32'h5, 32'h0, 4'h0);
      wait_rsp(r0);
      check("err_rresp", rsp_resp, 2'b11);
      check("err_rdata", rsp_rdata, 32'hDEADBEEF);
      cfg_rresp = 2'b00; cfg_r_override = 1'b0;
      repeat (6) @(negedge clk);
      check("err_no_retry", {aw_hs_cnt - aw0, ar_hs_cnt - ar0}, {32'd1, 32'd1});
      check("err_idle", busy, 1'b0);

      // Command held high while busy; the second one takes the values present at acceptance
      a0 = acc_cnt; r0 = rsp_cnt; aw0 = aw_hs_cnt;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h2; cmd_wdata = 32'h11; cmd_wstrb = 4'hF;
      for (int i = 0; i < 40 && acc_cnt == a0; i++) @(negedge clk);
      first_edge = acc_edge;
      cmd_addr = 32'h3; cmd_wdata = 32'h22;
      for (int i = 0; i < 40 && (acc_cnt - a0) < 2; i++) @(negedge clk);
      cmd_valid = 1'b0;
      check("busy_two_accepts", acc_cnt - a0, 2);
      check("busy_spacing", acc_edge - first_edge, 4);
      for (int i = 0; i < 60 && (rsp_cnt - r0) < 2; i++) @(negedge clk);
      @(negedge clk);
      check("busy_rsp_count", rsp_cnt - r0, 2);
      check("busy_aw_count", aw_hs_cnt - aw0, 2);
      check("busy_second_awaddr", seen_awaddr, 32'h3);
      check("busy_mem_first", mem[2], 32'h11);
      check("busy_mem_second", mem[3], 32'h22);

      // Reset while waiting in RD_DATA
      cfg_r_stall = 1'b1;
      send(1'b0, 32'h1, 32'h0, 4'h0);
      for (int i = 0; i < 20 && !axi.rready; i++) @(negedge clk);
      check("mid_rd_in_rdata", axi.rready, 1'b1);
      r0 = rsp_cnt;
      rst = 1'b1;
      #1;
      check("mid_rd_valids", {axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready}, 5'b0);
      check("mid_rd_rsp_busy", {rsp_valid, busy, rsp_resp}, 4'b0);
      check("mid_rd_payload", {axi.awaddr, axi.wdata, axi.araddr, rsp_rdata}, 128'h0);
      check("mid_rd_cmd_ready", cmd_ready, 1'b1);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      cfg_r_stall = 1'b0;
      repeat (2) @(negedge clk);
      check("mid_rd_no_rsp", rsp_cnt - r0, 0);
      r0 = rsp_cnt;
      send(1'b0, 32'h1, 32'h0, 4'h0);
      wait_rsp(r0);
      check("post_rst_rdata", rsp_rdata, 32'h6);
      check("post_rst_resp", rsp_resp, 2'b00);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
